// File: rtl/mac_feeder.sv
// mac_feeder: sequences (input, weight) pairs from two read-latency-1 memories
// into a downstream mac, one output neuron at a time. It captures each neuron's
// accumulated result and hands it out over a valid/ready handshake.
module mac_feeder #(
  parameter int unsigned A_WIDTH     = 8,
  parameter int unsigned B_WIDTH     = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned N_IN        = 4,
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned MAC_LATENCY = 1,
  // Address/index widths, clamped to at least one bit for degenerate sizes
  localparam int unsigned XW = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned WW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int unsigned NW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  output logic                 busy,
  output logic                 done,
  output logic [XW-1:0]        x_addr,
  input  logic [A_WIDTH-1:0]   x_data,
  output logic [WW-1:0]        w_addr,
  input  logic [B_WIDTH-1:0]   w_data,
  output logic                 mac_start,
  output logic                 mac_valid,
  output logic [A_WIDTH-1:0]   mac_a,
  output logic [B_WIDTH-1:0]   mac_b,
  input  logic [ACC_WIDTH-1:0] mac_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [NW-1:0]        out_idx
);

  // Wait counter must hold 0..MAC_LATENCY
  localparam int unsigned LW = $clog2(MAC_LATENCY + 2);

  localparam logic [XW-1:0] KLast = XW'(N_IN - 1);
  localparam logic [NW-1:0] NLast = NW'(N_OUT - 1);
  localparam logic [LW-1:0] WLast = LW'(MAC_LATENCY);

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StWait,
    StOut
  } state_t;

  state_t        state_q;
  logic [XW-1:0] k_q;
  logic [NW-1:0] neuron_q;
  logic [LW-1:0] wait_q;

  // Memory data lands one cycle after the address, exactly when the issue
  // flags are high, so the operands can pass straight through.
  assign mac_a = x_data;
  assign mac_b = w_data;

  // Sequencer FSM; every output except the operand pass-through is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      neuron_q  <= '0;
      wait_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_start <= 1'b0;
      mac_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      x_addr    <= '0;
      w_addr    <= '0;
    end else begin
      done      <= 1'b0;
      mac_start <= 1'b0;
      mac_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            state_q  <= StFeed;
            k_q      <= '0;
            neuron_q <= '0;
            x_addr   <= '0;
            w_addr   <= '0;
            busy     <= 1'b1;
          end
        end

        StFeed: begin
          // Flags describe the pair whose address is out this cycle; they
          // become visible together with that pair's memory data.
          mac_start <= (k_q == '0);
          mac_valid <= (k_q != '0);
          if (k_q == KLast) begin
            state_q <= StWait;
            wait_q  <= '0;
          end else begin
            k_q    <= k_q + 1'b1;
            x_addr <= x_addr + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end

        StWait: begin
          if (wait_q == WLast) begin
            out_data  <= mac_result;
            out_idx   <= neuron_q;
            out_valid <= 1'b1;
            state_q   <= StOut;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (neuron_q == NLast) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
              neuron_q <= neuron_q + 1'b1;
              k_q      <= '0;
              x_addr   <= '0;
              // Row-major weights: last address of this row + 1 is the next row base
              w_addr   <= w_addr + 1'b1;
              state_q  <= StFeed;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
